// File: rtl/acc_exec_core_pkg.sv
// Shared constants for the accumulator CPU execution core: opcodes, ALU ops, datapath width.
package acc_exec_core_pkg;

  localparam int DW = 8;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_SLT = 3'b010;
  localparam logic [2:0] OP_LW  = 3'b011;
  localparam logic [2:0] OP_SW  = 3'b100;
  localparam logic [2:0] OP_LI  = 3'b101;
  localparam logic [2:0] OP_LA  = 3'b110;
  localparam logic [2:0] OP_JAL = 3'b111;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_SLT  = 2'b10;
  localparam logic [1:0] ALU_LINK = 2'b11;

  function automatic logic [DW-1:0] sign_ext_imm(input logic [4:0] imm5);
    return {{(DW-5){imm5[4]}}, imm5};
  endfunction

endpackage

// File: rtl/acc_exec_core_if.sv
// Datapath bundle between the execution core and the surrounding latches, PC, memory and register file.
interface acc_exec_core_if;
  import acc_exec_core_pkg::*;

  logic [DW-1:0] instr;
  logic [DW-1:0] reg_rd;
  logic [DW-1:0] reg_buf;
  logic [DW-1:0] pc_addr;
  logic [DW-1:0] alu_out;
  logic [DW-1:0] acc_out;
  logic [4:0]    imm;
  logic [1:0]    cntr_alu;
  logic          reg_we;
  logic          mem_we;
  logic          brnch;
  logic          alu_sc;
  logic          lw;
  logic          acc_we;
  logic          acc_sc;
  logic          mem_sc;

  modport master (
    output instr, reg_rd, reg_buf, pc_addr,
    input  alu_out, acc_out, imm, cntr_alu,
    input  reg_we, mem_we, brnch, alu_sc, lw, acc_we, acc_sc, mem_sc
  );

  modport slave (
    input  instr, reg_rd, reg_buf, pc_addr,
    output alu_out, acc_out, imm, cntr_alu,
    output reg_we, mem_we, brnch, alu_sc, lw, acc_we, acc_sc, mem_sc
  );

endinterface

// File: rtl/acc_exec_alu.sv
// Combinational ALU: add/sub modulo 256, signed set-less-than, and pc+1 link value.
module acc_exec_alu
  import acc_exec_core_pkg::*;
(
  input  logic [1:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] pc,
  output logic [DW-1:0] result
);

  always_comb begin
    result = '0;
    unique case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLT:  result = ($signed(a) < $signed(b)) ? {{(DW-1){1'b0}}, 1'b1} : '0;
      ALU_LINK: result = pc + {{(DW-1){1'b0}}, 1'b1};
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/acc_exec_core.sv
// Execution core: opcode decoder, accumulator with source mux, and the ALU instance.
module acc_exec_core
  import acc_exec_core_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  acc_exec_core_if.slave bus
);

  logic [2:0]    opcode;
  logic [4:0]    imm5;
  logic [1:0]    cntr;
  logic          reg_we_dec, mem_we_dec, brnch_dec, acc_we_dec;
  logic          alu_sc_dec, lw_dec, acc_sc_dec, mem_sc_dec;
  logic [DW-1:0] acc_q;
  logic [DW-1:0] acc_src;
  logic [DW-1:0] alu_res;

  assign opcode = bus.instr[7:5];
  assign imm5   = bus.instr[4:0];

  always_comb begin
    cntr       = ALU_ADD;
    reg_we_dec = 1'b0;
    mem_we_dec = 1'b0;
    brnch_dec  = 1'b0;
    alu_sc_dec = 1'b0;
    lw_dec     = 1'b0;
    acc_we_dec = 1'b0;
    acc_sc_dec = 1'b0;
    mem_sc_dec = 1'b0;
    unique case (opcode)
      OP_ADD: begin cntr = ALU_ADD; alu_sc_dec = 1'b1; reg_we_dec = 1'b1; end
      OP_SUB: begin cntr = ALU_SUB; alu_sc_dec = 1'b1; reg_we_dec = 1'b1; end
      OP_SLT: begin cntr = ALU_SLT; alu_sc_dec = 1'b1; reg_we_dec = 1'b1; end
      OP_LW:  begin mem_sc_dec = 1'b1; lw_dec = 1'b1; reg_we_dec = 1'b1; end
      OP_SW:  begin mem_sc_dec = 1'b1; mem_we_dec = 1'b1; end
      OP_LI:  begin acc_we_dec = 1'b1; acc_sc_dec = 1'b1; end
      OP_LA:  begin acc_we_dec = 1'b1; end
      OP_JAL: begin cntr = ALU_LINK; brnch_dec = 1'b1; reg_we_dec = 1'b1; end
      default: ;
    endcase
  end

  // Only state-changing strobes are suppressed in reset; selects keep decoding.
  assign bus.reg_we   = reg_we_dec & ~reset;
  assign bus.mem_we   = mem_we_dec & ~reset;
  assign bus.brnch    = brnch_dec  & ~reset;
  assign bus.acc_we   = acc_we_dec & ~reset;
  assign bus.alu_sc   = alu_sc_dec;
  assign bus.lw       = lw_dec;
  assign bus.acc_sc   = acc_sc_dec;
  assign bus.mem_sc   = mem_sc_dec;
  assign bus.cntr_alu = cntr;
  assign bus.imm      = imm5;

  assign acc_src = acc_sc_dec ? sign_ext_imm(imm5) : bus.reg_rd;

  always_ff @(posedge clk) begin
    if (reset)
      acc_q <= '0;
    else if (acc_we_dec)
      acc_q <= acc_src;
  end

  assign bus.acc_out = acc_q;

  acc_exec_alu u_alu (
    .op     (cntr),
    .a      (acc_q),
    .b      (bus.reg_buf),
    .pc     (bus.pc_addr),
    .result (alu_res)
  );

  assign bus.alu_out = alu_res;

endmodule

// File: tb/tb_acc_exec_core.sv
// Directed self-checking bench for acc_exec_core.
module tb_acc_exec_core;
  import acc_exec_core_pkg::*;

  logic clk;
  logic reset;
  int   tests;
  int   failed;

  acc_exec_core_if bus ();

  acc_exec_core dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // strobe vector order: reg_we mem_we brnch alu_sc lw acc_we acc_sc mem_sc
  function automatic logic [7:0] ctl_vec();
    return {bus.reg_we, bus.mem_we, bus.brnch, bus.alu_sc,
            bus.lw, bus.acc_we, bus.acc_sc, bus.mem_sc};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] i, input logic [7:0] rd,
                       input logic [7:0] rb, input logic [7:0] pc);
    bus.instr   = i;
    bus.reg_rd  = rd;
    bus.reg_buf = rb;
    bus.pc_addr = pc;
    #1;
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    reset  = 1'b1;
    drive(8'hA3, 8'h00, 8'h00, 8'h00);
    edge_step();
    edge_step();
    chk("reset_acc_init", bus.acc_out, 8'h00);
    chk("reset_ctl_li", ctl_vec(), 8'b0000_0010);

    // preload 5A via LA, then reset with an ADD present
    reset = 1'b0;
    drive(8'hC0, 8'h5A, 8'h00, 8'h00);
    chk("la_ctl", ctl_vec(), 8'b0000_0100);
    edge_step();
    chk("preload_5a", bus.acc_out, 8'h5A);
    reset = 1'b1;
    drive(8'h00, 8'h00, 8'h00, 8'h00);
    chk("reset_ctl_add", ctl_vec(), 8'b0001_0000);
    chk("reset_cntr_add", {6'b0, bus.cntr_alu}, 8'h00);
    edge_step();
    chk("reset_clears_acc", bus.acc_out, 8'h00);

    // preload again, then reset with LI present: reset wins
    reset = 1'b0;
    drive(8'hC0, 8'h5A, 8'h00, 8'h00);
    edge_step();
    chk("preload_5a_2", bus.acc_out, 8'h5A);
    reset = 1'b1;
    drive(8'hA3, 8'h00, 8'h00, 8'h00);
    chk("reset_li_acc_we", {7'b0, bus.acc_we}, 8'h00);
    edge_step();
    chk("reset_beats_li", bus.acc_out, 8'h00);
    reset = 1'b0;

    // LI sign extension
    drive(8'hBF, 8'h00, 8'h00, 8'h00);
    chk("li_ctl", ctl_vec(), 8'b0000_0110);
    chk("li_imm", {3'b0, bus.imm}, 8'h1F);
    edge_step();
    chk("li_neg", bus.acc_out, 8'hFF);
    drive(8'hAF, 8'h00, 8'h00, 8'h00);
    edge_step();
    chk("li_pos", bus.acc_out, 8'h0F);

    drive(8'hC0, 8'h3C, 8'h00, 8'h00);
    edge_step();
    chk("la_load", bus.acc_out, 8'h3C);

    // acc = F0 via LI imm 10000
    drive(8'hB0, 8'h00, 8'h00, 8'h00);
    edge_step();
    chk("li_f0", bus.acc_out, 8'hF0);

    drive(8'h00, 8'h00, 8'h20, 8'h00);
    chk("add_res", bus.alu_out, 8'h10);
    chk("add_ctl", ctl_vec(), 8'b1001_0000);
    chk("add_cntr", {6'b0, bus.cntr_alu}, 8'h00);
    drive(8'h20, 8'h00, 8'h20, 8'h00);
    chk("sub_res", bus.alu_out, 8'hD0);
    chk("sub_cntr", {6'b0, bus.cntr_alu}, 8'h01);
    drive(8'h40, 8'h00, 8'h20, 8'h00);
    chk("slt_true", bus.alu_out, 8'h01);
    chk("slt_cntr", {6'b0, bus.cntr_alu}, 8'h02);
    edge_step();
    chk("alu_keeps_acc", bus.acc_out, 8'hF0);

    drive(8'hC0, 8'h20, 8'h00, 8'h00);
    edge_step();
    chk("la_20", bus.acc_out, 8'h20);
    drive(8'h40, 8'h00, 8'hF0, 8'h00);
    chk("slt_false", bus.alu_out, 8'h00);

    drive(8'hE2, 8'h00, 8'h00, 8'hFF);
    chk("jal_ctl", ctl_vec(), 8'b1010_0000);
    chk("jal_cntr", {6'b0, bus.cntr_alu}, 8'h03);
    chk("jal_wrap", bus.alu_out, 8'h00);
    drive(8'hE2, 8'h00, 8'h00, 8'h41);
    chk("jal_link", bus.alu_out, 8'h42);

    drive(8'h61, 8'h77, 8'h00, 8'h00);
    chk("lw_ctl", ctl_vec(), 8'b1000_1001);
    edge_step();
    chk("lw_keeps_acc", bus.acc_out, 8'h20);
    drive(8'h81, 8'h77, 8'h00, 8'h00);
    chk("sw_ctl", ctl_vec(), 8'b0100_0001);
    edge_step();
    chk("sw_keeps_acc", bus.acc_out, 8'h20);

    // back-to-back accumulator loads
    drive(8'hA5, 8'h99, 8'h00, 8'h00);
    edge_step();
    chk("b2b_li", bus.acc_out, 8'h05);
    drive(8'hC0, 8'h99, 8'h00, 8'h00);
    edge_step();
    chk("b2b_la", bus.acc_out, 8'h99);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
